// File: rtl/tlb_refill_walker_if.sv
// Bundle of the TLB-miss, memory-read and TLB-write signals used by tlb_refill_walker.
// The master modport is the walker side; slave is the surrounding core/memory side.
interface tlb_refill_walker_if;
  logic        miss_req;
  logic [5:0]  miss_asid;
  logic [7:0]  miss_vpn;
  logic [15:0] ptbr;
  logic        busy;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        tlb_we;
  logic [5:0]  tlb_asid;
  logic [7:0]  tlb_vpn;
  logic [7:0]  tlb_pfn;
  logic        tlb_v;
  logic        done;
  logic        fault;
  logic [1:0]  fault_code;

  modport master (
    input  miss_req, miss_asid, miss_vpn, ptbr, mem_rdata, mem_ack,
    output busy, mem_req, mem_addr, tlb_we, tlb_asid, tlb_vpn, tlb_pfn, tlb_v,
           done, fault, fault_code
  );

  modport slave (
    output miss_req, miss_asid, miss_vpn, ptbr, mem_rdata, mem_ack,
    input  busy, mem_req, mem_addr, tlb_we, tlb_asid, tlb_vpn, tlb_pfn, tlb_v,
           done, fault, fault_code
  );
endinterface

// File: rtl/tlb_refill_walker.sv
// Hardware TLB refill engine: fetches the PTE for a missing {asid, vpn} and writes the TLB.
// Optional bus watchdog compiled in with `define TLB_REFILL_TIMEOUT_EN.
module tlb_refill_walker #(
  parameter int         PTE_V_BIT = 15,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input logic           clk,
  input logic           reset,
  tlb_refill_walker_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, FAULT} state_t;

  state_t     state;
  logic [5:0] asid_q;
  logic [7:0] vpn_q;

`ifdef TLB_REFILL_TIMEOUT_EN
  logic [7:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // All outputs are registered; pulses are cleared on the cycle after they are raised.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      asid_q         <= '0;
      vpn_q          <= '0;
      bus.busy       <= 1'b0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.tlb_we     <= 1'b0;
      bus.tlb_asid   <= '0;
      bus.tlb_vpn    <= '0;
      bus.tlb_pfn    <= '0;
      bus.tlb_v      <= 1'b0;
      bus.done       <= 1'b0;
      bus.fault      <= 1'b0;
      bus.fault_code <= 2'b00;
`ifdef TLB_REFILL_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.miss_req) begin
            asid_q       <= bus.miss_asid;
            vpn_q        <= bus.miss_vpn;
            bus.mem_addr <= bus.ptbr + {2'b00, bus.miss_asid, bus.miss_vpn};
            bus.mem_req  <= 1'b1;
            bus.busy     <= 1'b1;
            state        <= READ;
`ifdef TLB_REFILL_TIMEOUT_EN
            wait_cnt     <= '0;
`endif
          end
        end

        READ: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (bus.mem_rdata[PTE_V_BIT]) begin
              bus.tlb_we   <= 1'b1;
              bus.done     <= 1'b1;
              bus.tlb_v    <= 1'b1;
              bus.tlb_pfn  <= bus.mem_rdata[7:0];
              bus.tlb_asid <= asid_q;
              bus.tlb_vpn  <= vpn_q;
              state        <= WRITE;
            end else begin
              bus.fault      <= 1'b1;
              bus.fault_code <= 2'b01;
              state          <= FAULT;
            end
          end
`ifdef TLB_REFILL_TIMEOUT_EN
          // An ack in the cycle the count reaches TIMEOUT takes priority above.
          else if (wait_cnt == TIMEOUT - 8'd1) begin
            bus.mem_req    <= 1'b0;
            bus.fault      <= 1'b1;
            bus.fault_code <= 2'b10;
            state          <= FAULT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        WRITE: begin
          bus.tlb_we <= 1'b0;
          bus.done   <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end

        FAULT: begin
          bus.fault <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed plus randomized bench for tlb_refill_walker with a transaction-level reference model.
// Build with or without TLB_REFILL_TIMEOUT_EN; the watchdog is instantiated with TIMEOUT=4.
module tb_tlb_refill_walker;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_refill_walker_if bus();

  tlb_refill_walker #(.PTE_V_BIT(15), .TIMEOUT(8'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef TLB_REFILL_TIMEOUT_EN
  localparam int WRAP_WAITS = 3;
`else
  localparam int WRAP_WAITS = 5;
`endif

  int checks = 0;
  int errors = 0;

  // Model of the architecturally visible TLB-write fields and fault code.
  logic [5:0] m_asid;
  logic [7:0] m_vpn;
  logic [7:0] m_pfn;
  logic       m_v;
  logic [1:0] m_code;

  task automatic modelReset();
    m_asid = '0; m_vpn = '0; m_pfn = '0; m_v = 1'b0; m_code = 2'b00;
  endtask

  function automatic logic [15:0] refAddr(input int p, input int a, input int v);
    return 16'((p + a * 256 + v) % 65536);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [15:0] p, input logic [5:0] a,
                               input logic [7:0] v, input logic ack, input logic [15:0] rd);
    bus.miss_req  = req;
    bus.ptbr      = p;
    bus.miss_asid = a;
    bus.miss_vpn  = v;
    bus.mem_ack   = ack;
    bus.mem_rdata = rd;
  endtask

  task automatic applyNoise(input logic req, input logic ack, input logic [15:0] rd);
    applyStimulus(req, 16'($urandom), 6'($urandom), 8'($urandom), ack, rd);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".busy"},       32'(bus.busy),       32'(0));
    checkOutput({tag, ".mem_req"},    32'(bus.mem_req),    32'(0));
    checkOutput({tag, ".tlb_we"},     32'(bus.tlb_we),     32'(0));
    checkOutput({tag, ".done"},       32'(bus.done),       32'(0));
    checkOutput({tag, ".fault"},      32'(bus.fault),      32'(0));
    checkOutput({tag, ".tlb_asid"},   32'(bus.tlb_asid),   32'(m_asid));
    checkOutput({tag, ".tlb_vpn"},    32'(bus.tlb_vpn),    32'(m_vpn));
    checkOutput({tag, ".tlb_pfn"},    32'(bus.tlb_pfn),    32'(m_pfn));
    checkOutput({tag, ".tlb_v"},      32'(bus.tlb_v),      32'(m_v));
    checkOutput({tag, ".fault_code"}, 32'(bus.fault_code), 32'(m_code));
  endtask

  // One complete walk: accept, `waits` cycles without ack, ack with rd, response, back to IDLE.
  task automatic walk(input string tag, input logic [15:0] p, input logic [5:0] a,
                      input logic [7:0] v, input logic [15:0] rd, input int waits);
    logic [15:0] ea;
    logic        valid;
    ea    = refAddr(int'(p), int'(a), int'(v));
    valid = (rd >= 16'h8000);
    applyStimulus(1'b1, p, a, v, 1'b0, 16'($urandom));
    tick();
    checkOutput({tag, ".acc.busy"},    32'(bus.busy),     32'(1));
    checkOutput({tag, ".acc.mem_req"}, 32'(bus.mem_req),  32'(1));
    checkOutput({tag, ".acc.addr"},    32'(bus.mem_addr), 32'(ea));
    applyNoise(1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < waits; i++) begin
      tick();
      checkOutput({tag, ".wait.mem_req"}, 32'(bus.mem_req),  32'(1));
      checkOutput({tag, ".wait.addr"},    32'(bus.mem_addr), 32'(ea));
    end
    applyNoise(1'b1, 1'b1, rd);
    tick();
    if (valid) begin
      m_asid = a; m_vpn = v; m_pfn = 8'(rd % 256); m_v = 1'b1;
    end else begin
      m_code = 2'b01;
    end
    checkOutput({tag, ".rsp.mem_req"},    32'(bus.mem_req),    32'(0));
    checkOutput({tag, ".rsp.busy"},       32'(bus.busy),       32'(1));
    checkOutput({tag, ".rsp.tlb_we"},     32'(bus.tlb_we),     32'(valid));
    checkOutput({tag, ".rsp.done"},       32'(bus.done),       32'(valid));
    checkOutput({tag, ".rsp.fault"},      32'(bus.fault),      32'(!valid));
    checkOutput({tag, ".rsp.fault_code"}, 32'(bus.fault_code), 32'(m_code));
    checkOutput({tag, ".rsp.tlb_asid"},   32'(bus.tlb_asid),   32'(m_asid));
    checkOutput({tag, ".rsp.tlb_vpn"},    32'(bus.tlb_vpn),    32'(m_vpn));
    checkOutput({tag, ".rsp.tlb_pfn"},    32'(bus.tlb_pfn),    32'(m_pfn));
    checkOutput({tag, ".rsp.tlb_v"},      32'(bus.tlb_v),      32'(m_v));
    applyNoise(1'b0, 1'b0, 16'($urandom));
    tick();
    checkIdle({tag, ".post"});
  endtask

  initial begin
    logic [15:0] ea;

    // Reset held for two cycles with a pending miss.
    reset = 1'b0;
    applyStimulus(1'b1, 16'h0200, 6'h00, 8'hC9, 1'b0, 16'h0000);
    modelReset();
    tick();
    tick();
    checkIdle("reset");
    checkOutput("reset.mem_addr", 32'(bus.mem_addr), 32'(0));
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 6'h00, 8'h00, 1'b0, 16'h0000);
    tick();
    checkOutput("reset.idle_busy", 32'(bus.busy), 32'(0));

    // Directed hit, not-present, and wrap-around with wait states.
    walk("hit",   16'h0200, 6'h00, 8'hC9, 16'h8002, 0);
    walk("npres", 16'h0200, 6'h00, 8'hC9, 16'h0002, 0);
    walk("wrap",  16'hFFF0, 6'h3F, 8'h20, 16'hC0A5, WRAP_WAITS);

    // Reset during READ, then a late ack must do nothing.
    applyStimulus(1'b1, 16'h1234, 6'h05, 8'h66, 1'b0, 16'h0000);
    tick();
    checkOutput("midrst.mem_req", 32'(bus.mem_req), 32'(1));
    tick();
    reset = 1'b0;
    tick();
    modelReset();
    checkIdle("midrst.rst");
    checkOutput("midrst.mem_addr", 32'(bus.mem_addr), 32'(0));
    reset = 1'b1;
    applyStimulus(1'b0, 16'h1234, 6'h05, 8'h66, 1'b1, 16'h8055);
    tick();
    checkIdle("midrst.lateack");
    applyStimulus(1'b0, 16'h0000, 6'h00, 8'h00, 1'b0, 16'h0000);

    // Back-to-back: miss_req held high across two misses.
    applyStimulus(1'b1, 16'h0400, 6'h01, 8'h10, 1'b0, 16'h0000);
    tick();
    checkOutput("b2b.a.addr", 32'(bus.mem_addr), 32'(refAddr(16'h0400, 6'h01, 8'h10)));
    applyStimulus(1'b1, 16'h0800, 6'h02, 8'h33, 1'b1, 16'h8077);
    tick();
    m_asid = 6'h01; m_vpn = 8'h10; m_pfn = 8'h77; m_v = 1'b1;
    checkOutput("b2b.a.done",     32'(bus.done),     32'(1));
    checkOutput("b2b.a.tlb_vpn",  32'(bus.tlb_vpn),  32'(m_vpn));
    checkOutput("b2b.a.tlb_asid", 32'(bus.tlb_asid), 32'(m_asid));
    bus.mem_ack = 1'b0;
    tick();
    checkOutput("b2b.idle.busy", 32'(bus.busy), 32'(0));
    tick();
    ea = refAddr(16'h0800, 6'h02, 8'h33);
    checkOutput("b2b.b.busy", 32'(bus.busy),     32'(1));
    checkOutput("b2b.b.addr", 32'(bus.mem_addr), 32'(ea));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h8099;
    tick();
    m_asid = 6'h02; m_vpn = 8'h33; m_pfn = 8'h99; m_v = 1'b1;
    checkOutput("b2b.b.done",    32'(bus.done),    32'(1));
    checkOutput("b2b.b.tlb_vpn", 32'(bus.tlb_vpn), 32'(m_vpn));
    checkOutput("b2b.b.tlb_pfn", 32'(bus.tlb_pfn), 32'(m_pfn));
    applyStimulus(1'b0, 16'h0000, 6'h00, 8'h00, 1'b0, 16'h0000);
    tick();
    checkIdle("b2b.post");

    // Randomized walks against the model.
    for (int n = 0; n < 24; n++) begin
      walk("rand", 16'($urandom), 6'($urandom), 8'($urandom), 16'($urandom),
           int'($urandom_range(0, 3)));
    end

`ifdef TLB_REFILL_TIMEOUT_EN
    // Watchdog: no ack for TIMEOUT READ cycles gives a bus-timeout fault.
    applyStimulus(1'b1, 16'h0100, 6'h07, 8'h01, 1'b0, 16'h0000);
    tick();
    applyNoise(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("tmo.wait.mem_req", 32'(bus.mem_req), 32'(1));
    end
    tick();
    m_code = 2'b10;
    checkOutput("tmo.fault",      32'(bus.fault),      32'(1));
    checkOutput("tmo.fault_code", 32'(bus.fault_code), 32'(m_code));
    checkOutput("tmo.mem_req",    32'(bus.mem_req),    32'(0));
    checkOutput("tmo.tlb_we",     32'(bus.tlb_we),     32'(0));
    applyNoise(1'b0, 1'b0, 16'h0000);
    tick();
    checkIdle("tmo.post");
    walk("tmo.ackwins", 16'h0300, 6'h09, 8'h44, 16'h80EE, 3);
`else
    // Without the watchdog READ waits indefinitely.
    applyStimulus(1'b1, 16'h0100, 6'h07, 8'h01, 1'b0, 16'h0000);
    tick();
    applyNoise(1'b0, 1'b0, 16'h0000);
    repeat (300) tick();
    checkOutput("nowd.mem_req", 32'(bus.mem_req),    32'(1));
    checkOutput("nowd.busy",    32'(bus.busy),       32'(1));
    checkOutput("nowd.fault",   32'(bus.fault),      32'(0));
    checkOutput("nowd.code",    32'(bus.fault_code), 32'(m_code));
    reset = 1'b0;
    tick();
    modelReset();
    reset = 1'b1;
    tick();
    checkIdle("nowd.post");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
